// File: rtl/summator_serial_nbit_if.sv
// rtl/summator_serial_nbit_if.sv - operand/strobe and result bundle for the bit-serial adder
interface summator_serial_nbit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] input_number0;
  logic [WIDTH-1:0] input_number1;
  logic             input_mode_sub;
  logic             input_write_enabled;
  logic [WIDTH-1:0] output_sum;
  logic             output_carry;
  logic             output_overflow;
  logic             output_calculated;
  logic             output_busy;

  modport master (
    output input_number0, input_number1, input_mode_sub, input_write_enabled,
    input  output_sum, output_carry, output_overflow, output_calculated, output_busy
  );

  modport slave (
    input  input_number0, input_number1, input_mode_sub, input_write_enabled,
    output output_sum, output_carry, output_overflow, output_calculated, output_busy
  );
endinterface

// File: rtl/summator_serial_nbit.sv
// rtl/summator_serial_nbit.sv - WIDTH-bit serial add/sub through one full-adder slice, LSB first
module summator_serial_nbit #(
  parameter int WIDTH         = 8,
  parameter int serial_number = 0
) (
  input logic                  input_clk,
  input logic                  input_reset,
  summator_serial_nbit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  // Reject degenerate widths and negative instance ids at elaboration.
  if (WIDTH < 1 || serial_number < 0) begin : g_param_check
    $error("summator_serial_nbit: WIDTH must be >= 1 and serial_number >= 0");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_overflow;

  logic             w_start;
  logic             w_last;
  logic             w_s;
  logic             w_cout;

  // A start is only honoured when no computation is running (IDLE or DONE).
  assign w_start = bus.input_write_enabled && (r_state != SHIFT);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // Single full-adder slice working on the current LSBs.
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  assign bus.output_sum        = r_sum;
  assign bus.output_carry      = r_carry;
  assign bus.output_overflow   = r_overflow;
  assign bus.output_calculated = (r_state == DONE);
  assign bus.output_busy       = (r_state == SHIFT);

  // State register.
  always_ff @(posedge input_clk or negedge input_reset) begin
    if (!input_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: DONE lasts one cycle unless a back-to-back start arrives.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = w_start ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge input_clk or negedge input_reset) begin
    if (!input_reset) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= 1'b0;
      r_psum     <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      r_cnt  <= '0;
      r_a    <= bus.input_number0;
      r_b    <= bus.input_number1 ^ {WIDTH{bus.input_mode_sub}};
      r_c    <= bus.input_mode_sub;
      r_psum <= '0;
    end else if (r_state == SHIFT) begin
      r_cnt  <= r_cnt + 1'b1;
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_c    <= w_cout;
      r_psum <= WIDTH'({w_s, r_psum} >> 1);
      if (w_last) begin
        // r_c here is the carry into the MSB, so overflow is c_in(MSB) ^ c_out(MSB).
        r_sum      <= WIDTH'({w_s, r_psum} >> 1);
        r_carry    <= w_cout;
        r_overflow <= r_c ^ w_cout;
      end
    end
  end

endmodule

// File: tb/tb_summator_serial_nbit.sv
// tb/tb_summator_serial_nbit.sv - directed self-checking bench for summator_serial_nbit
module tb_summator_serial_nbit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  summator_serial_nbit_if #(.WIDTH(8)) if8 ();
  summator_serial_nbit_if #(.WIDTH(1)) if1 ();

  summator_serial_nbit #(.WIDTH(8), .serial_number(0)) dut8 (
    .input_clk   (clk),
    .input_reset (rst_n),
    .bus         (if8)
  );

  summator_serial_nbit #(.WIDTH(1), .serial_number(1)) dut1 (
    .input_clk   (clk),
    .input_reset (rst_n),
    .bus         (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full WIDTH=8 transaction with exact latency and pulse-width checks.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    if8.input_number0       = a;
    if8.input_number1       = b;
    if8.input_mode_sub      = sub;
    if8.input_write_enabled = 1'b1;
    @(posedge clk); #1;
    if8.input_write_enabled = 1'b0;
    check({tag, "_busy_e0"}, 32'(if8.output_busy), 32'd1);
    repeat (7) begin @(posedge clk); #1; end
    check({tag, "_busy_e7"}, 32'(if8.output_busy), 32'd1);
    check({tag, "_calc_e7"}, 32'(if8.output_calculated), 32'd0);
    @(posedge clk); #1;
    check({tag, "_calc_e8"}, 32'(if8.output_calculated), 32'd1);
    check({tag, "_busy_e8"}, 32'(if8.output_busy), 32'd0);
    check({tag, "_sum"}, 32'(if8.output_sum), 32'(es));
    check({tag, "_carry"}, 32'(if8.output_carry), 32'(ec));
    check({tag, "_ovf"}, 32'(if8.output_overflow), 32'(eo));
    @(posedge clk); #1;
    check({tag, "_calc_e9"}, 32'(if8.output_calculated), 32'd0);
  endtask

  // WIDTH=1 add: result one clock after the accepting edge.
  task automatic op1(input string tag, input logic a, input logic b,
                     input logic [1:0] ecs, input logic eo);
    @(negedge clk);
    if1.input_number0       = a;
    if1.input_number1       = b;
    if1.input_mode_sub      = 1'b0;
    if1.input_write_enabled = 1'b1;
    @(posedge clk); #1;
    if1.input_write_enabled = 1'b0;
    check({tag, "_busy"}, 32'(if1.output_busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_calc"}, 32'(if1.output_calculated), 32'd1);
    check({tag, "_cs"}, 32'({if1.output_carry, if1.output_sum}), 32'(ecs));
    check({tag, "_ovf"}, 32'(if1.output_overflow), 32'(eo));
  endtask

  initial begin
    int pulses;
    int held;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if8.input_number0 = '0; if8.input_number1 = '0;
    if8.input_mode_sub = 1'b0; if8.input_write_enabled = 1'b0;
    if1.input_number0 = '0; if1.input_number1 = '0;
    if1.input_mode_sub = 1'b0; if1.input_write_enabled = 1'b0;

    #12;
    check("rst_sum", 32'(if8.output_sum), 32'd0);
    check("rst_carry", 32'(if8.output_carry), 32'd0);
    check("rst_ovf", 32'(if8.output_overflow), 32'd0);
    check("rst_calc", 32'(if8.output_calculated), 32'd0);
    check("rst_busy", 32'(if8.output_busy), 32'd0);
    check("rst1_busy", 32'(if1.output_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

    // Strobe while busy is ignored; then a back-to-back start in the DONE cycle.
    @(negedge clk);
    if8.input_number0 = 8'h10; if8.input_number1 = 8'h20;
    if8.input_mode_sub = 1'b0; if8.input_write_enabled = 1'b1;
    @(posedge clk); #1;
    if8.input_write_enabled = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      pulses += int'(if8.output_calculated);
      if (i == 2) begin
        if8.input_number0 = 8'hAA; if8.input_number1 = 8'h55; if8.input_write_enabled = 1'b1;
      end
      if (i == 3) if8.input_write_enabled = 1'b0;
    end
    check("b2b_no_early_pulse", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    check("b2b_calc1", 32'(if8.output_calculated), 32'd1);
    check("b2b_sum1", 32'(if8.output_sum), 32'h30);
    if8.input_number0 = 8'h01; if8.input_number1 = 8'h01; if8.input_write_enabled = 1'b1;
    @(posedge clk); #1;
    if8.input_write_enabled = 1'b0;
    check("b2b_calc_drop", 32'(if8.output_calculated), 32'd0);
    check("b2b_busy_rise", 32'(if8.output_busy), 32'd1);
    held = 1;
    repeat (7) begin
      @(posedge clk); #1;
      if (if8.output_sum !== 8'h30) held = 0;
    end
    check("b2b_sum_held", 32'(held), 32'd1);
    @(posedge clk); #1;
    check("b2b_calc2", 32'(if8.output_calculated), 32'd1);
    check("b2b_sum2", 32'(if8.output_sum), 32'h02);

    // Asynchronous reset mid-computation.
    @(negedge clk);
    if8.input_number0 = 8'h33; if8.input_number1 = 8'h11; if8.input_write_enabled = 1'b1;
    @(posedge clk); #1;
    if8.input_write_enabled = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(if8.output_sum), 32'd0);
    check("arst_busy", 32'(if8.output_busy), 32'd0);
    check("arst_calc", 32'(if8.output_calculated), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      pulses += int'(if8.output_calculated);
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);
    check("arst_sum_zero", 32'(if8.output_sum), 32'd0);
    op8("post_rst_33_11", 8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

    // WIDTH=1 truth table.
    op1("w1_00", 1'b0, 1'b0, 2'b00, 1'b0);
    op1("w1_01", 1'b0, 1'b1, 2'b01, 1'b0);
    op1("w1_10", 1'b1, 1'b0, 2'b01, 1'b0);
    op1("w1_11", 1'b1, 1'b1, 2'b10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/summator_serial_nbit.md
Name: summator_serial_nbit

Overview:
Parametrised bit-serial adder/subtractor; successor to the 1-bit summator. Captures two WIDTH-bit operands on a write strobe and processes one bit per clock through a single full-adder slice, LSB first. It then presents sum, carry and signed overflow with a one-cycle done pulse. Used where area matters more than latency, e.g. accumulating counters in the summator chain.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
serial_number, 0, instance identifier for bench messages; no functional effect

Ports:
input_clk  in  1  clock, rising-edge
input_reset  in  1  asynchronous, active-low reset
input_number0  in  WIDTH  operand A (unsigned or two's complement)
input_number1  in  WIDTH  operand B
input_mode_sub  in  1  0: A+B, 1: A-B; sampled with start
input_write_enabled  in  1  start strobe; accepted only when output_busy=0
output_sum  out  WIDTH  result, registered, held until next result
output_carry  out  1  carry out of MSB (sub: 1 = no borrow, A>=B unsigned)
output_overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB
output_calculated  out  1  one-cycle pulse: result outputs just updated
output_busy  out  1  high while a computation is in progress

Behaviour:
- Reset (input_reset=0, asynchronous): state IDLE; output_sum=0, output_carry=0, output_overflow=0, output_calculated=0, output_busy=0; bit counter, operand and partial-sum shift registers cleared. Takes effect immediately even mid-operation; the in-flight result is discarded, no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + input_write_enabled=1 at edge 0: latch A, B XOR {WIDTH{mode_sub}}, carry register <= mode_sub; counter <= 0; go SHIFT; output_busy=1 from edge 0.
- SHIFT: each edge computes s = a[0]^b[0]^c, c' = majority(a[0],b[0],c); shifts A and B right; shifts s into partial sum from MSB side; counter +1. On the edge processing bit WIDTH-1 (edge WIDTH), record carry-in to that bit for overflow.
- At edge WIDTH: output_sum, output_carry, output_overflow load together; output_calculated=1, output_busy=0; state DONE. Latency from accepting edge to valid result = WIDTH clocks.
- DONE lasts one cycle: without a new start, go IDLE at the next edge and drop output_calculated. Start in DONE is accepted (back-to-back): output_calculated drops, output_busy rises, and the previous result outputs stay held.
- input_write_enabled while output_busy=1 is ignored; operands and mode are not resampled.
- Result outputs change only at edge WIDTH of a computation or at reset.
- Arithmetic is modulo 2^WIDTH; no saturation. Counter width clog2(WIDTH+1).
- WIDTH=1: overflow = initial carry XOR carry out; the result must match the 1-bit summator truth table.

Test Plan:
- WIDTH=8, add 0x0F+0x01, strobe 1 cycle -> busy high 8 cycles, then sum=0x10, carry=0, overflow=0, calculated pulse exactly 1 cycle at clock 8.
- Add 0xFF+0x01 -> sum=0x00, carry=1, overflow=0. Add 0x7F+0x01 -> sum=0x80, carry=0, overflow=1.
- Sub 0x05-0x07 -> sum=0xFE, carry=0 (borrow), overflow=0. Sub 0x80-0x01 -> sum=0x7F, carry=1, overflow=1.
- Start 0x10+0x20, strobe again at cycle 3 with 0xAA+0x55 -> second strobe ignored; result 0x30, exactly one done pulse. Then strobe in the DONE cycle with 0x01+0x01 -> 0x02 after 8 more clocks; 0x30 held until then.
- Assert input_reset low at cycle 4 of a computation, asynchronous to the clock edge -> all outputs 0 immediately, no calculated pulse; a fresh start after release gives the correct result.
- WIDTH=1, all four operand pairs in add mode -> {carry,sum} = 00,01,01,10, each valid 1 clock after strobe.
